// File: rtl/bnn_result_reader_if.sv
// Bus bundle for the BNN result reader: score-vector input handshake,
// winning-class report and the host-bound byte stream.
interface bnn_result_reader_if #(
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W     = 7
);
  logic [NUM_CLASSES*SCORE_W-1:0] scores_i;
  logic                           scores_valid_i;
  logic                           scores_ready_o;
  logic [3:0]                     class_o;
  logic                           class_valid_o;
  logic [7:0]                     tx_data_o;
  logic                           tx_valid_o;
  logic                           tx_ready_i;
  logic                           busy_o;

  // Reader side (the design).
  modport slave (
    input  scores_i, scores_valid_i, tx_ready_i,
    output scores_ready_o, class_o, class_valid_o, tx_data_o, tx_valid_o, busy_o
  );

  // Environment side (score producer and byte consumer).
  modport master (
    output scores_i, scores_valid_i, tx_ready_i,
    input  scores_ready_o, class_o, class_valid_o, tx_data_o, tx_valid_o, busy_o
  );
endinterface

// File: rtl/bnn_result_reader.sv
// BNN result reader: latches a class-score vector, runs a one-class-per-cycle
// argmax (ties go to the lowest index), then streams a result frame
//   0xA5, {4'h0, class}, score[0] .. score[NUM_CLASSES-1]
// toward the host.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. The score input is accepted only in IDLE (scores_ready_o=1). On the
// byte stream, once tx_valid_o rises it stays high and tx_data_o stays stable
// until the byte is taken with tx_ready_i.
module bnn_result_reader #(
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W     = 7
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  bnn_result_reader_if.slave bus,
  output logic [1:0]         dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    SEND = 2'd2
  } state_e;

  // Index of the last class scanned, and of the last byte of the frame.
  localparam logic [3:0] LAST_IDX  = 4'(NUM_CLASSES - 1);
  localparam logic [4:0] LAST_BYTE = 5'(NUM_CLASSES + 1);

  state_e             state_q, state_d;
  // Score storage is always 16 deep so a 4-bit index never runs out of
  // range; entries above NUM_CLASSES-1 are tied to zero.
  logic [SCORE_W-1:0] scores_in [16];
  logic [SCORE_W-1:0] scores_q  [16];
  logic [SCORE_W-1:0] scores_d  [16];
  logic [SCORE_W-1:0] best_q, best_d;
  logic [3:0]         best_idx_q, best_idx_d;
  logic [3:0]         idx_q, idx_d;
  logic [3:0]         class_q, class_d;
  logic               class_valid_q, class_valid_d;
  logic [4:0]         byte_cnt_q, byte_cnt_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;

  logic               cand_gt;
  logic [4:0]         next_bidx;
  logic [3:0]         next_sidx;
  logic [7:0]         next_byte;

  // Unpack the flat score bus into per-class lanes.
  for (genvar k = 0; k < 16; k++) begin : g_unpack
    if (k < NUM_CLASSES) begin : g_used
      assign scores_in[k] = bus.scores_i[k*SCORE_W +: SCORE_W];
    end else begin : g_unused
      assign scores_in[k] = '0;
    end
  end

  // Strict compare: an equal score never displaces the earlier winner.
  assign cand_gt   = scores_q[idx_q] > best_q;
  // Byte that follows the one currently on tx_data_o.
  assign next_bidx = byte_cnt_q + 5'd1;
  assign next_sidx = 4'(next_bidx - 5'd2);
  assign next_byte = (next_bidx == 5'd1) ? {4'h0, class_q} : 8'(scores_q[next_sidx]);

  // Next-state and register-update logic for the accept/scan/send sequence.
  always_comb begin
    state_d       = state_q;
    for (int k = 0; k < 16; k++) scores_d[k] = scores_q[k];
    best_d        = best_q;
    best_idx_d    = best_idx_q;
    idx_d         = idx_q;
    class_d       = class_q;
    class_valid_d = 1'b0;
    byte_cnt_d    = byte_cnt_q;
    tx_data_d     = tx_data_q;
    tx_valid_d    = tx_valid_q;

    case (state_q)
      IDLE: begin
        if (bus.scores_valid_i) begin
          for (int k = 0; k < 16; k++) scores_d[k] = scores_in[k];
          best_d     = scores_in[0];
          best_idx_d = 4'd0;
          idx_d      = 4'd1;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        if (cand_gt) begin
          best_d     = scores_q[idx_q];
          best_idx_d = idx_q;
        end
        idx_d = idx_q + 4'd1;
        if (idx_q == LAST_IDX) begin
          class_d       = cand_gt ? idx_q : best_idx_q;
          class_valid_d = 1'b1;
          tx_valid_d    = 1'b1;
          tx_data_d     = 8'hA5;
          byte_cnt_d    = 5'd0;
          state_d       = SEND;
        end
      end
      SEND: begin
        if (bus.tx_ready_i) begin
          if (byte_cnt_q == LAST_BYTE) begin
            tx_valid_d = 1'b0;
            byte_cnt_d = 5'd0;
            state_d    = IDLE;
          end else begin
            byte_cnt_d = next_bidx;
            tx_data_d  = next_byte;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight frame.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      for (int k = 0; k < 16; k++) scores_q[k] <= '0;
      best_q        <= '0;
      best_idx_q    <= 4'd0;
      idx_q         <= 4'd0;
      class_q       <= 4'd0;
      class_valid_q <= 1'b0;
      byte_cnt_q    <= 5'd0;
      tx_data_q     <= 8'h00;
      tx_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      for (int k = 0; k < 16; k++) scores_q[k] <= scores_d[k];
      best_q        <= best_d;
      best_idx_q    <= best_idx_d;
      idx_q         <= idx_d;
      class_q       <= class_d;
      class_valid_q <= class_valid_d;
      byte_cnt_q    <= byte_cnt_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
    end
  end

  assign bus.scores_ready_o = (state_q == IDLE);
  assign bus.busy_o         = (state_q != IDLE);
  assign bus.class_o        = class_q;
  assign bus.class_valid_o  = class_valid_q;
  assign bus.tx_data_o      = tx_data_q;
  assign bus.tx_valid_o     = tx_valid_q;
  assign dbg_state_o        = state_q;

endmodule
